// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter with atomic bursts, feeding a
// single-entry registered output channel.

// Per-requester ready/transfer logic. Ready is only raised for the granted
// requester while the output register can take a beat.
module mux2_rr_lane (
  input  logic rst,
  input  logic granted,
  input  logic free,
  input  logic v,
  output logic r,
  output logic take
);
  assign r    = ~rst & granted & free;
  assign take = v & r;
endmodule

module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic             v0,
  input  logic             l0,
  output logic             r0,
  input  logic [WIDTH-1:0] d1,
  input  logic             v1,
  input  logic             l1,
  output logic             r1,
  output logic [WIDTH-1:0] q,
  output logic             qv,
  output logic             ql,
  input  logic             qr,
  output logic             sel,
  output logic             err
);
  localparam int NUM_CH = 2;
  localparam int CW     = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                         state, state_nxt;
  logic                           prio_last, prio_nxt;
  logic [CW-1:0]                  cnt, cnt_nxt;
  logic                           err_nxt;
  logic                           free, xfer, l_sel;
  logic [WIDTH-1:0]               d_sel;
  logic [NUM_CH-1:0]              v_vec, l_vec, r_vec, take_vec, gnt_vec;
  logic [NUM_CH-1:0][WIDTH-1:0]   d_vec;

  assign v_vec = {v1, l1} == 2'b00 ? {v1, v0} : {v1, v0};
  assign l_vec = {l1, l0};
  assign d_vec = {d1, d0};
  assign r0    = r_vec[0];
  assign r1    = r_vec[1];

  // Output slot can accept a beat when empty or draining this cycle.
  assign free    = ~qv | qr;
  assign gnt_vec = sel ? 2'b10 : 2'b01;
  assign xfer    = |take_vec;
  assign d_sel   = d_vec[sel];
  assign l_sel   = l_vec[sel];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    mux2_rr_lane u_lane (
      .rst    (rst),
      .granted(gnt_vec[i]),
      .free   (free),
      .v      (v_vec[i]),
      .r      (r_vec[i]),
      .take   (take_vec[i])
    );
  end

  // Grant selection: alternate on ties in IDLE, stick with the owner mid-burst.
  always_comb begin
    sel = 1'b0;
    case (state)
      IDLE:    sel = (v0 & v1) ? ~prio_last : v1;
      OWN0:    sel = 1'b0;
      OWN1:    sel = 1'b1;
      default: sel = 1'b0;
    endcase
  end

  // Next-state, burst length tracking and overflow detection.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio_last;
    cnt_nxt   = cnt;
    err_nxt   = err;
    if (xfer) begin
      if (state == IDLE) begin
        prio_nxt = sel;
        if (l_sel) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt   = CW'(1);
          state_nxt = sel ? OWN1 : OWN0;
        end
      end else begin
        if (cnt == CNT_MAX) err_nxt = 1'b1;
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        if (l_sel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio_last <= 1'b1;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio_last <= prio_nxt;
      cnt       <= cnt_nxt;
      err       <= err_nxt;
    end
  end

  // Single-entry output register; load and drain may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      qv <= 1'b0;
      ql <= 1'b0;
    end else if (xfer) begin
      q  <= d_sel;
      ql <= l_sel;
      qv <= 1'b1;
    end else if (qv & qr) begin
      qv <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table, directed burst
// sequences and randomized traffic against a transaction-level model.
module tb_mux2_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int MAXB  = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [WIDTH-1:0] d0 = '0, d1 = '0, q;
  logic v0 = 0, l0 = 0, v1 = 0, l1 = 0, qr = 0;
  logic r0, r1, qv, ql, sel, err;

  int checks = 0, failures = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .d0(d0), .v0(v0), .l0(l0), .r0(r0),
    .d1(d1), .v1(v1), .l1(l1), .r1(r1), .q(q), .qv(qv), .ql(ql),
    .qr(qr), .sel(sel), .err(err)
  );

  always #5 clk = ~clk;

  // Model: who owns the channel (-1 = nobody), who won the last arbitration,
  // how many beats the current burst has moved, and the output slot contents.
  int         m_owner = -1, m_last = 1, m_beats = 0;
  bit         m_err = 0, m_qv = 0, m_ql = 0;
  logic [7:0] m_q = '0;

  typedef struct {
    logic v0, l0; logic [7:0] d0;
    logic v1, l1; logic [7:0] d1;
    logic qr;
    logic e_r0, e_r1, e_sel, e_qv, e_ql; logic [7:0] e_q;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_beats = 0;
    m_err = 0; m_qv = 0; m_ql = 0; m_q = '0;
  endtask

  function automatic int winner();
    if (m_owner >= 0) return m_owner;
    if (v0 && v1) return 1 - m_last;
    return v1 ? 1 : 0;
  endfunction

  task automatic set_in(input logic a_v0, input logic a_l0, input logic [7:0] a_d0,
                        input logic a_v1, input logic a_l1, input logic [7:0] a_d1,
                        input logic a_qr);
    v0 = a_v0; l0 = a_l0; d0 = a_d0; v1 = a_v1; l1 = a_l1; d1 = a_d1; qr = a_qr;
  endtask

  // Compare against the model, advance one clock, update the model.
  task automatic cycle();
    int  w;
    bit  fr, x, lw;
    #1;
    w  = winner();
    fr = !m_qv || qr;
    check("r0",  r0,  (w == 0) && fr);
    check("r1",  r1,  (w == 1) && fr);
    check("sel", sel, w);
    check("qv",  qv,  m_qv);
    check("ql",  ql,  m_ql);
    check("q",   q,   m_q);
    check("err", err, m_err);
    @(posedge clk);
    x  = fr && ((w == 1) ? v1 : v0);
    lw = (w == 1) ? l1 : l0;
    if (x) begin
      if (m_owner < 0) m_last = w;
      m_beats++;
      if (m_beats > MAXB) m_err = 1;
      if (lw) begin m_owner = -1; m_beats = 0; end
      else m_owner = w;
      m_q  = (w == 1) ? d1 : d0;
      m_ql = lw;
      m_qv = 1;
    end else if (m_qv && qr) begin
      m_qv = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state while rst is held high.
    @(negedge clk);
    set_in(1, 1, 8'h5A, 1, 1, 8'hC3, 1);
    #1;
    check("rst_r0", r0, 0);
    check("rst_r1", r1, 0);
    check("rst_qv", qv, 0);
    check("rst_q",  q,  0);
    check("rst_err", err, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    model_reset();

    // Single beat, then alternating ties, then drain.
    tbl[0] = '{1,1,8'hA5, 0,0,8'h00, 1, 1,0,0, 0,0,8'h00};
    tbl[1] = '{1,1,8'h11, 1,1,8'h22, 1, 0,1,1, 1,1,8'hA5};
    tbl[2] = '{1,1,8'h33, 1,1,8'h44, 1, 1,0,0, 1,1,8'h22};
    tbl[3] = '{1,1,8'h55, 1,1,8'h66, 1, 0,1,1, 1,1,8'h33};
    tbl[4] = '{0,0,8'h00, 0,0,8'h00, 1, 1,0,0, 1,1,8'h66};
    tbl[5] = '{0,0,8'h00, 0,0,8'h00, 0, 1,0,0, 0,1,8'h66};
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].v0, tbl[i].l0, tbl[i].d0, tbl[i].v1, tbl[i].l1, tbl[i].d1, tbl[i].qr);
      #1;
      check($sformatf("tbl%0d_r0", i),  r0,  tbl[i].e_r0);
      check($sformatf("tbl%0d_r1", i),  r1,  tbl[i].e_r1);
      check($sformatf("tbl%0d_sel", i), sel, tbl[i].e_sel);
      check($sformatf("tbl%0d_qv", i),  qv,  tbl[i].e_qv);
      check($sformatf("tbl%0d_ql", i),  ql,  tbl[i].e_ql);
      check($sformatf("tbl%0d_q", i),   q,   tbl[i].e_q);
      cycle();
    end

    // ch1 burst of 3 while ch0 keeps requesting; ch1 has priority after ch0 won.
    set_in(1, 1, 8'h01, 1, 0, 8'hB1, 1); #1; check("b_pre_r0", r0, 1); cycle();
    set_in(1, 1, 8'h02, 1, 0, 8'hB1, 1); #1; check("b1_r0", r0, 0); check("b1_r1", r1, 1); cycle();
    set_in(1, 1, 8'h03, 1, 0, 8'hB2, 1); #1; check("b2_r0", r0, 0); check("b2_sel", sel, 1); cycle();
    set_in(1, 1, 8'h04, 1, 1, 8'hB3, 1); #1; check("b3_r0", r0, 0); cycle();
    set_in(1, 1, 8'h77, 0, 0, 8'h00, 1); #1; check("b_post_r0", r0, 1); check("b_post_sel", sel, 0); cycle();

    // Backpressure: held beat stays put, readies drop.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 8'h88, 1, 1, 8'h99, 0); #1;
      check("bp_r0", r0, 0); check("bp_r1", r1, 0);
      check("bp_qv", qv, 1); check("bp_q", q, 8'h77); check("bp_ql", ql, 1);
      cycle();
    end
    set_in(1, 1, 8'h88, 0, 0, 8'h00, 1); #1; check("bp_rel_r0", r0, 1); cycle();
    check("bp_new_q", q, 8'h88); check("bp_new_qv", qv, 1);

    // Burst length limit: 16 beats fine, 17th beat flags err, err sticks.
    for (int b = 1; b <= 16; b++) begin
      set_in(1, b == 16, 8'(b), 0, 0, 0, 1); cycle();
    end
    check("len16_err", err, 0);
    for (int b = 1; b <= 17; b++) begin
      set_in(1, b == 17, 8'(b + 8'h40), 0, 0, 0, 1); cycle();
      if (b == 16) check("len17_pre_err", err, 0);
    end
    check("len17_err", err, 1);
    set_in(0, 0, 0, 1, 1, 8'hEE, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0, 1); cycle();
    check("err_sticky", err, 1);

    // Reset in the middle of a burst with a held beat.
    set_in(1, 0, 8'hD0, 0, 0, 0, 1); cycle();
    set_in(1, 0, 8'hD1, 0, 0, 0, 1); cycle();
    #2 rst = 1;
    #1;
    check("mid_rst_qv", qv, 0); check("mid_rst_err", err, 0);
    check("mid_rst_r0", r0, 0); check("mid_rst_r1", r1, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    set_in(1, 1, 8'h12, 1, 1, 8'h34, 1); #1;
    check("post_rst_sel", sel, 0); check("post_rst_r0", r0, 1);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 3) == 0, 8'($urandom),
             $urandom_range(0, 1), $urandom_range(0, 3) == 0, 8'($urandom),
             $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
